// File: rtl/frisc_lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
// Holds the RV32 funct3 width codes, the FSM state type and the decode helpers.
package frisc_lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  // Stores only know B/H/W; loads also allow the unsigned byte/half forms.
  function automatic logic f3Illegal(input logic store, input logic [2:0] f3);
    if (store) return (f3 > 3'b010);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic [3:0] storeMask(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0001;
      3'b001:  return 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational load-data extension: picks the low byte/half/word of the raw
// memory word and sign- or zero-extends it according to funct3.
module lsu_extend
  import frisc_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = 32'h0;
    case (funct3_e'(i_funct3))
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_W:    o_data = i_raw;
      F3_BU:   o_data = {24'h0, i_raw[7:0]};
      F3_HU:   o_data = {16'h0, i_raw[15:0]};
      default: o_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store unit front end: IDLE -> ACCESS -> RESP handshake around a byte-addressed memory.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_align
  import frisc_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err
);

  state_e                r_state;
  state_e                w_next;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_respData;
  logic                  r_respErr;
  logic                  w_err;
  logic [31:0]           w_extData;

  lsu_extend u_extend (
    .i_funct3 (r_funct3),
    .i_raw    (mem_rdata),
    .o_data   (w_extData)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = f3Illegal(r_store, r_funct3) | misaligned(r_funct3, r_addr[1:0]);
`else
  assign w_err = f3Illegal(r_store, r_funct3);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_wmask  = 4'b0000;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    resp_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (r_store && !w_err) mem_wmask = storeMask(r_funct3);
        w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_data  = r_respData;
        resp_err   = r_respErr;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory offsets bytes by address itself, so address and data pass through untouched.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_store  <= req_store;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_respData <= 32'h0;
      r_respErr  <= 1'b0;
    end else if (r_state == S_ACCESS) begin
      r_respData <= (r_store || w_err) ? 32'h0 : w_extData;
      r_respErr  <= w_err;
    end
  end

endmodule
